// File: rtl/xspi_target_responder_if.sv
// xspi_target_responder_if: command/response bus between the xSPI slave decoder and the target responder
// Ports (signals):
//   cmd_valid/cmd_ready          command handshake
//   cmd, addr, wdata             opcode, 48-bit word address, 64-bit write data
//   crc_ca_error, crc_data_error CRC check results qualified by cmd_valid
//   rsp_valid/rsp_ready          response handshake
//   rsp_status, rsp_rdata        00 OK, 01 RETRY, 10 ABORT, 11 BAD; read data
// Modports: master = host/decoder side, slave = responder side.
interface xspi_target_responder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd;
    logic [47:0] addr;
    logic [63:0] wdata;
    logic        crc_ca_error;
    logic        crc_data_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [63:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd, addr, wdata, crc_ca_error, crc_data_error, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd, addr, wdata, crc_ca_error, crc_data_error, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status, rsp_rdata
    );
endinterface

// File: rtl/xspi_target_responder.sv
// xspi_target_responder: executes CRC-checked xSPI write/read commands against a word store and returns one status response per command
// Ports:
//   clk            clock, all logic on posedge
//   rst            asynchronous active-high reset
//   bus            command/response interface (slave modport)
//   retry_cnt      consecutive CRC-failure count
//   crc_err_total  saturating count of all CRC-failed transactions
module xspi_target_responder #(
    parameter int       DEPTH     = 16,
    parameter int       MAX_RETRY = 3,
    parameter bit [7:0] CMD_WR    = 8'hA5,
    parameter bit [7:0] CMD_RD    = 8'hFF
) (
    input  logic                               clk,
    input  logic                               rst,
    xspi_target_responder_if.slave             bus,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
    output logic [7:0]                         crc_err_total
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_RETRY = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;
    localparam logic [1:0] ST_BAD   = 2'b11;

    logic [1:0]  state;
    logic [7:0]  cmd_q;
    logic [47:0] addr_q;
    logic [63:0] wdata_q;
    logic        ca_q;
    logic        de_q;
    logic [1:0]  status_q;
    logic [63:0] rdata_q;
    logic [63:0] mem [DEPTH];

    logic          is_wr;
    logic          is_rd;
    logic          crc_fail;
    logic          addr_ok;
    logic          retry_ok;
    logic [AW-1:0] idx;

    assign is_wr    = cmd_q == CMD_WR;
    assign is_rd    = cmd_q == CMD_RD;
    // Data CRC only matters for writes; read-data CRC is checked by the host.
    assign crc_fail = ca_q | (is_wr & de_q);
    assign addr_ok  = addr_q[47:AW] == '0;
    assign retry_ok = (32'(retry_cnt) + 32'd1) < 32'(MAX_RETRY);
    assign idx      = addr_q[AW-1:0];

    // Handshake flags come straight from the state so an async reset drops rsp_valid at once.
    assign bus.cmd_ready  = state == IDLE;
    assign bus.rsp_valid  = state == RESP;
    assign bus.rsp_status = status_q;
    assign bus.rsp_rdata  = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cmd_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            ca_q          <= 1'b0;
            de_q          <= 1'b0;
            status_q      <= ST_OK;
            rdata_q       <= '0;
            retry_cnt     <= '0;
            crc_err_total <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == IDLE) begin
            if (bus.cmd_valid) begin
                cmd_q   <= bus.cmd;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                ca_q    <= bus.crc_ca_error;
                de_q    <= bus.crc_data_error;
                state   <= EXEC;
            end
        end else if (state == EXEC) begin
            rdata_q <= '0;
            state   <= RESP;
            if (crc_fail) begin
                status_q      <= retry_ok ? ST_RETRY : ST_ABORT;
                retry_cnt     <= retry_ok ? retry_cnt + RW'(1) : '0;
                crc_err_total <= (crc_err_total == 8'hFF) ? 8'hFF : crc_err_total + 8'd1;
            end else begin
                retry_cnt <= '0;
                if (!(is_wr || is_rd) || !addr_ok) begin
                    status_q <= ST_BAD;
                end else if (is_wr) begin
                    mem[idx] <= wdata_q;
                    status_q <= ST_OK;
                end else begin
                    rdata_q  <= mem[idx];
                    status_q <= ST_OK;
                end
            end
        end else begin
            if (bus.rsp_ready) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_xspi_target_responder.sv
// tb_xspi_target_responder: randomized self-checking bench for xspi_target_responder against a behavioural model
module tb_xspi_target_responder;
    localparam int DEPTH     = 16;
    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] retry_cnt;
    logic [7:0] crc_err_total;

    xspi_target_responder_if bus();

    xspi_target_responder #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .retry_cnt(retry_cnt),
        .crc_err_total(crc_err_total)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] mdl_mem [DEPTH];
    int          mdl_retry;
    int          mdl_total;
    logic [1:0]  exp_st;
    logic [63:0] exp_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        mdl_retry = 0;
        mdl_total = 0;
    endtask

    task automatic model(input logic [7:0] c, input logic [47:0] a, input logic [63:0] wd,
                         input logic ca, input logic de);
        exp_rd = '0;
        if (ca || (c == 8'hA5 && de)) begin
            mdl_total = (mdl_total < 255) ? mdl_total + 1 : 255;
            if (mdl_retry + 1 < MAX_RETRY) begin
                exp_st = 2'b01;
                mdl_retry++;
            end else begin
                exp_st = 2'b10;
                mdl_retry = 0;
            end
        end else begin
            mdl_retry = 0;
            if ((c != 8'hA5 && c != 8'hFF) || a >= 48'(DEPTH)) exp_st = 2'b11;
            else if (c == 8'hA5) begin
                mdl_mem[int'(a)] = wd;
                exp_st = 2'b00;
            end else begin
                exp_rd = mdl_mem[int'(a)];
                exp_st = 2'b00;
            end
        end
    endtask

    // Called just after a negedge; returns at the negedge where rsp_valid is first seen.
    task automatic issue(input logic [7:0] c, input logic [47:0] a, input logic [63:0] wd,
                         input logic ca, input logic de);
        int lat;
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd = c;
        bus.addr = a;
        bus.wdata = wd;
        bus.crc_ca_error = ca;
        bus.crc_data_error = de;
        bus.cmd_valid = 1'b1;
        model(c, a, wd, ca, de);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.cmd_valid = 1'b0;
                check("cmd_ready_exec", 64'(bus.cmd_ready), 64'd0);
            end
        end while (!bus.rsp_valid && lat < 20);
        check("latency", 64'(lat), 64'd2);
        check("status", 64'(bus.rsp_status), 64'(exp_st));
        check("rdata", bus.rsp_rdata, exp_rd);
        check("retry_cnt", 64'(retry_cnt), 64'(mdl_retry));
        check("crc_err_total", 64'(crc_err_total), 64'(mdl_total));
    endtask

    task automatic consume(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_status", 64'(bus.rsp_status), 64'(exp_st));
            check("hold_rdata", bus.rsp_rdata, exp_rd);
            check("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic txn(input logic [7:0] c, input logic [47:0] a, input logic [63:0] wd,
                       input logic ca, input logic de, input int hold);
        issue(c, a, wd, ca, de);
        consume(hold);
    endtask

    initial begin
        logic [7:0]  c;
        logic [47:0] a;
        int          r;
        bus.cmd_valid = 1'b0;
        bus.cmd = '0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.crc_ca_error = 1'b0;
        bus.crc_data_error = 1'b0;
        bus.rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_status", 64'(bus.rsp_status), 64'd0);
        check("rst_rdata", bus.rsp_rdata, 64'd0);
        check("rst_retry", 64'(retry_cnt), 64'd0);
        check("rst_total", 64'(crc_err_total), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        txn(8'hA5, 48'h3, 64'h1122334455667788, 1'b0, 1'b0, 0);
        txn(8'hFF, 48'h3, 64'h0, 1'b0, 1'b0, 1);
        check("t1_rdata_const", exp_rd, 64'h1122334455667788);

        txn(8'hA5, 48'h3, 64'hDEAD, 1'b0, 1'b1, 0);
        check("t2_retry", 64'(retry_cnt), 64'd1);
        txn(8'hFF, 48'h3, 64'h0, 1'b0, 1'b1, 0);

        for (int i = 0; i < 3; i++) txn(8'hA5, 48'h5, 64'h55, 1'b1, 1'b0, 0);
        txn(8'hA5, 48'h5, 64'h55, 1'b0, 1'b0, 0);

        txn(8'h12, 48'h1, 64'h0, 1'b0, 1'b0, 0);
        txn(8'hFF, 48'h6655443322AB, 64'h0, 1'b0, 1'b0, 0);
        txn(8'h12, 48'h1, 64'h0, 1'b1, 1'b0, 0);

        txn(8'hFF, 48'h3, 64'h0, 1'b0, 1'b0, 5);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            c = (r < 4) ? 8'hA5 : (r < 8) ? 8'hFF : 8'($urandom);
            a = ($urandom_range(0, 7) == 0) ? {16'($urandom), 32'($urandom)} : 48'($urandom_range(0, DEPTH - 1));
            txn(c, a, {$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3));
        end

        for (int n = 0; n < 260; n++) txn(8'hFF, 48'h0, 64'h0, 1'b1, 1'b0, 0);
        check("sat_total", 64'(crc_err_total), 64'hFF);

        issue(8'hFF, 48'h3, 64'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("post_rst_retry", 64'(retry_cnt), 64'd0);
        check("post_rst_total", 64'(crc_err_total), 64'd0);
        txn(8'hFF, 48'h3, 64'h0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
